// File: rtl/hms_time_ctrl.sv
// Mode/position sequencer for the HMS clock: button debounce, 1 Hz timebase, increment enables
// and setup blink mask. Define AUTO_REPEAT_EN to add hold-to-repeat on the increment button.
module hms_time_ctrl #(
    parameter int unsigned DIV_1HZ    = 50000000,
    parameter int unsigned DIV_SMP    = 500000,
    parameter int unsigned REPEAT_DLY = 50,
    parameter int unsigned REPEAT_PER = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_hour_inc,
    output logic [1:0] o_mode,
    output logic [5:0] o_blink
);

    typedef enum logic [1:0] {
        StClock   = 2'd0,
        StSetSec  = 2'd1,
        StSetMin  = 2'd2,
        StSetHour = 2'd3
    } mode_e;

    localparam int unsigned W1hz = $clog2(DIV_1HZ);
    localparam int unsigned WSmp = (DIV_SMP > 2) ? $clog2(DIV_SMP) : 1;
    localparam logic [W1hz-1:0] Last1hz = W1hz'(DIV_1HZ - 1);
    localparam logic [W1hz-1:0] Half1hz = W1hz'(DIV_1HZ / 2);
    localparam logic [WSmp-1:0] LastSmp = WSmp'(DIV_SMP - 1);

    mode_e            mode_q, mode_d;
    logic [W1hz-1:0]  cnt_1hz_q, cnt_1hz_d;
    logic [WSmp-1:0]  cnt_smp_q, cnt_smp_d;
    logic [2:0]       smp1_q, smp1_d, smp2_q, smp2_d, stable_q, stable_d;
    logic [2:0]       inc_q, inc_d;
    logic [5:0]       blink_q, blink_d;
    logic [2:0]       press;
    logic             tick_1hz, tick_smp, mode_chg, rep_fire;

    assign tick_1hz = (cnt_1hz_q == Last1hz);
    assign tick_smp = (cnt_smp_q == LastSmp);
    assign mode_chg = (mode_d != mode_q);

    // Press fires once when both samples read low while the debounced level is still released.
    assign press = ~smp1_q & ~smp2_q & stable_q;

    always_comb begin
        smp1_d   = smp1_q;
        smp2_d   = smp2_q;
        if (tick_smp) begin
            smp1_d = {i_sw2, i_sw1, i_sw0};
            smp2_d = smp1_q;
        end
        stable_d = (smp1_q & smp2_q) | (stable_q & (smp1_q | smp2_q));
    end

    always_comb begin
        mode_d = mode_q;
        if (press[0]) begin
            mode_d = (mode_q == StClock) ? StSetSec : StClock;
        end else if (press[1]) begin
            case (mode_q)
                StSetSec:  mode_d = StSetMin;
                StSetMin:  mode_d = StSetHour;
                StSetHour: mode_d = StSetSec;
                default:   mode_d = mode_q;
            endcase
        end
    end

    always_comb begin
        cnt_1hz_d = tick_1hz ? '0 : cnt_1hz_q + 1'b1;
        if (mode_chg && mode_d == StClock) begin
            cnt_1hz_d = '0;
        end
        cnt_smp_d = tick_smp ? '0 : cnt_smp_q + 1'b1;
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned WRep = $clog2(REPEAT_DLY + 1);
    logic [WRep-1:0] rep_q, rep_d, rep_inc;

    // After the first repeat, reload so the next one lands REPEAT_PER ticks later.
    always_comb begin
        rep_inc  = rep_q + 1'b1;
        rep_fire = 1'b0;
        rep_d    = rep_q;
        if (mode_q == StClock || stable_q[2] || mode_chg) begin
            rep_d = '0;
        end else if (tick_smp) begin
            if (rep_inc == WRep'(REPEAT_DLY)) begin
                rep_fire = 1'b1;
                rep_d    = WRep'(REPEAT_DLY - REPEAT_PER);
            end else begin
                rep_d = rep_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DLY, REPEAT_PER};
    assign rep_fire   = 1'b0;
`endif

    always_comb begin
        inc_d = '0;
        if (!mode_chg) begin
            unique case (mode_q)
                StClock: begin
                    if (tick_1hz) begin
                        inc_d = {(i_sec == 6'd59) && (i_min == 6'd59), i_sec == 6'd59, 1'b1};
                    end
                end
                StSetSec:  inc_d[0] = press[2] | rep_fire;
                StSetMin:  inc_d[1] = press[2] | rep_fire;
                StSetHour: inc_d[2] = press[2] | rep_fire;
                default:   inc_d = '0;
            endcase
        end
    end

    always_comb begin
        blink_d = '0;
        if (cnt_1hz_q >= Half1hz) begin
            unique case (mode_q)
                StSetSec:  blink_d = 6'b000011;
                StSetMin:  blink_d = 6'b001100;
                StSetHour: blink_d = 6'b110000;
                default:   blink_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= StClock;
            cnt_1hz_q <= '0;
            cnt_smp_q <= '0;
            smp1_q    <= '1;
            smp2_q    <= '1;
            stable_q  <= '1;
            inc_q     <= '0;
            blink_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            cnt_1hz_q <= cnt_1hz_d;
            cnt_smp_q <= cnt_smp_d;
            smp1_q    <= smp1_d;
            smp2_q    <= smp2_d;
            stable_q  <= stable_d;
            inc_q     <= inc_d;
            blink_q   <= blink_d;
        end
    end

    // Hours never gate anything here; the counter owns its own wrap.
    logic unused_hour;
    assign unused_hour = ^i_hour;

    assign o_sec_inc  = inc_q[0];
    assign o_min_inc  = inc_q[1];
    assign o_hour_inc = inc_q[2];
    assign o_mode     = mode_q;
    assign o_blink    = blink_q;

endmodule
